tcb_sub_mem: RTL

- TCB subordinate (responder) backed by a byte-addressed memory array.
- It is the end of the bus that answers manager requests, and is used as the system RAM model and the endpoint in TCB benches.
- It accepts one request per cycle and returns read data and error status exactly DLY cycles after each transfer.
- It supports MEMORY and REFERENCE data placement, ascending and descending byte order, and aligned or unaligned access checking.

---
 rtl/tcb_pkg.sv | 37 +++
 rtl/tcb_lib_lane_rotate.sv | 51 +++++
 rtl/tcb_sub_mem.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tcb_pkg.sv
// Shared TCB types and helpers: parameter enums and the byte-enable generator.
package tcb_pkg;

  typedef enum logic {TCB_REFERENCE = 1'b0, TCB_MEMORY = 1'b1} tcb_par_mode_t;
  typedef enum logic {TCB_LOGARITHMIC = 1'b0, TCB_LINEAR = 1'b1} tcb_par_size_t;
  typedef enum logic {TCB_ASCENDING = 1'b0, TCB_DESCENDING = 1'b1} tcb_par_order_t;
  typedef enum logic {TCB_ALIGNED = 1'b0, TCB_UNALIGNED = 1'b1} tcb_par_align_t;

  // Direction of the lane rotator: LSB-aligned value to lanes, or lanes back to value.
  typedef enum logic {TCB_TO_LANES = 1'b0, TCB_FROM_LANES = 1'b1} tcb_rot_dir_t;

  // Widest lane count the byte-enable helper supports.
  localparam int unsigned TCB_BEW_MAX = 64;
  localparam int unsigned TCB_BEW_LOG = 6;

  // Lanes touched by a 2^siz byte access starting at byte offset within a bus word.
  function automatic logic [TCB_BEW_MAX-1:0] tcb_ben_gen(input int unsigned    siz,
                                                         input int unsigned    offset,
                                                         input tcb_par_order_t order,
                                                         input int unsigned    bew);
    logic [TCB_BEW_MAX-1:0] ben;
    int unsigned            n;
    ben = '0;
    n   = (siz < 31) ? (32'd1 << siz) : bew;
    for (int unsigned k = 0; k < TCB_BEW_MAX; k++) begin
      if ((k < n) && ((offset + k) < bew)) begin
        if (order == TCB_ASCENDING) begin
          ben[TCB_BEW_LOG'(offset + k)] = 1'b1;
        end else begin
          ben[TCB_BEW_LOG'(bew - 1 - offset - k)] = 1'b1;
        end
      end
    end
    return ben;
  endfunction

endpackage

// File: rtl/tcb_lib_lane_rotate.sv
// Byte rotator between an LSB-aligned 2^siz byte value and bus lanes.
// Descending order places the value big-endian, which reduces to a different rotate amount.
module tcb_lib_lane_rotate
  import tcb_pkg::*;
#(
  parameter int unsigned    DBW     = 32,
  parameter int unsigned    SLW     = 8,
  parameter tcb_par_order_t PAR_ORD = TCB_ASCENDING,
  localparam int unsigned   BEW     = DBW / SLW,
  localparam int unsigned   OFW     = $clog2(BEW),
  localparam int unsigned   SZW     = $clog2($clog2(BEW) + 1)
) (
  input  logic [DBW-1:0] i_data,
  input  logic [OFW-1:0] i_offset,
  input  logic [SZW-1:0] i_siz,
  input  tcb_rot_dir_t   i_dir,
  output logic [DBW-1:0] o_data
);

  localparam int unsigned LGB = $clog2(BEW);

  logic [2*DBW-1:0] w_dbl;
  int unsigned      w_n;
  int unsigned      w_rot;

  // Rotate by the lane position of the value's least significant byte.
  always_comb begin
    w_dbl  = '0;
    o_data = '0;
    w_n    = (32'(i_siz) > LGB) ? BEW : (32'd1 << i_siz);
    if (PAR_ORD == TCB_ASCENDING) begin
      w_rot = 32'(i_offset);
    end else begin
      w_rot = (2 * BEW - w_n - 32'(i_offset)) % BEW;
    end
    if (i_dir == TCB_TO_LANES) begin
      w_dbl  = {i_data, i_data} << (w_rot * SLW);
      o_data = w_dbl[2*DBW-1:DBW];
    end else begin
      w_dbl  = {i_data, i_data} >> (w_rot * SLW);
      o_data = w_dbl[DBW-1:0];
      // Bytes beyond the transfer size never carry data back to the manager.
      for (int unsigned j = 0; j < BEW; j++) begin
        if (j >= w_n) begin
          o_data[j*SLW +: SLW] = '0;
        end
      end
    end
  end

endmodule

// File: rtl/tcb_sub_mem.sv
// TCB subordinate backed by a byte-addressed memory with a DLY-cycle response pipeline.
module tcb_sub_mem
  import tcb_pkg::*;
#(
  parameter int unsigned    ABW     = 32,
  parameter int unsigned    DBW     = 32,
  parameter int unsigned    SLW     = 8,
  parameter int unsigned    DLY     = 1,
  parameter tcb_par_mode_t  PAR_MOD = TCB_MEMORY,
  parameter tcb_par_size_t  PAR_SIZ = TCB_LOGARITHMIC,
  parameter tcb_par_order_t PAR_ORD = TCB_ASCENDING,
  parameter tcb_par_align_t PAR_LGN = TCB_ALIGNED,
  parameter int unsigned    SIZE    = 4096,
  localparam int unsigned   BEW     = DBW / SLW,
  localparam int unsigned   SZW     = $clog2($clog2(BEW) + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tcb_vld,
  output logic           tcb_rdy,
  input  logic           tcb_wen,
  input  logic [ABW-1:0] tcb_adr,
  input  logic [SZW-1:0] tcb_siz,
  input  logic [BEW-1:0] tcb_ben,
  input  logic [DBW-1:0] tcb_wdt,
  output logic [DBW-1:0] tcb_rdt,
  output logic           tcb_err
);

  localparam int unsigned LGB = $clog2(BEW);
  localparam int unsigned OFW = LGB;
  localparam int unsigned MAW = $clog2(SIZE);

  typedef struct packed {
    logic           err;
    logic [DBW-1:0] rdt;
  } tcb_rsp_t;

  if (PAR_SIZ != TCB_LOGARITHMIC) begin : g_siz_chk
    $error("tcb_sub_mem: only logarithmic size encoding is supported");
  end
  if (DLY > 4) begin : g_dly_chk
    $error("tcb_sub_mem: DLY must be in 0..4");
  end
  if ((SIZE % BEW) != 0) begin : g_size_chk
    $error("tcb_sub_mem: SIZE must be a multiple of the lane count");
  end

  logic [SLW-1:0]     r_mem [SIZE];
  logic               r_rdy;
  logic [DBW-1:0]     r_rdt;

  logic               w_xfr;
  logic [OFW-1:0]     w_off;
  logic [MAW-OFW-1:0] w_wrd;
  int unsigned        w_n;
  logic               w_siz_err;
  logic               w_adr_err;
  logic               w_lgn_err;
  logic               w_err;
  logic [BEW-1:0]     w_ben;
  logic [DBW-1:0]     w_wdt;
  logic [DBW-1:0]     w_wdt_ref;
  logic [DBW-1:0]     w_rd_lanes;
  logic [DBW-1:0]     w_rdt_ref;
  tcb_rsp_t           w_rsp;
  logic               w_out_vld;
  tcb_rsp_t           w_out_rsp;

  // Byte offset inside the bus word that lane i holds.
  function automatic logic [OFW-1:0] lane_sel(input int unsigned i);
    return (PAR_ORD == TCB_ASCENDING) ? OFW'(i) : OFW'(BEW - 1 - i);
  endfunction

  assign w_xfr   = tcb_vld & r_rdy;
  assign tcb_rdy = r_rdy;
  assign w_off   = tcb_adr[OFW-1:0];
  assign w_wrd   = tcb_adr[MAW-1:OFW];

  // Error classification of the current request.
  always_comb begin
    w_siz_err = 32'(tcb_siz) > LGB;
    w_n       = w_siz_err ? BEW : (32'd1 << tcb_siz);
    w_adr_err = tcb_adr >= ABW'(SIZE);
    if (PAR_LGN == TCB_ALIGNED) begin
      w_lgn_err = (32'(w_off) & (w_n - 1)) != 0;
    end else begin
      w_lgn_err = (32'(w_off) + w_n) > BEW;
    end
    w_err = w_siz_err | w_adr_err | w_lgn_err;
  end

  tcb_lib_lane_rotate #(
    .DBW     (DBW),
    .SLW     (SLW),
    .PAR_ORD (PAR_ORD)
  ) u_rot_wr (
    .i_data   (tcb_wdt),
    .i_offset (w_off),
    .i_siz    (tcb_siz),
    .i_dir    (TCB_TO_LANES),
    .o_data   (w_wdt_ref)
  );

  tcb_lib_lane_rotate #(
    .DBW     (DBW),
    .SLW     (SLW),
    .PAR_ORD (PAR_ORD)
  ) u_rot_rd (
    .i_data   (w_rd_lanes),
    .i_offset (w_off),
    .i_siz    (tcb_siz),
    .i_dir    (TCB_FROM_LANES),
    .o_data   (w_rdt_ref)
  );

  assign w_ben = (PAR_MOD == TCB_MEMORY) ? tcb_ben :
                 BEW'(tcb_ben_gen(32'(tcb_siz), 32'(w_off), PAR_ORD, BEW));
  assign w_wdt = (PAR_MOD == TCB_MEMORY) ? tcb_wdt : w_wdt_ref;

  // Gather the addressed bus word into lanes.
  always_comb begin
    w_rd_lanes = '0;
    for (int unsigned i = 0; i < BEW; i++) begin
      w_rd_lanes[i*SLW +: SLW] = r_mem[{w_wrd, lane_sel(i)}];
    end
  end

  // Response of the current request; writes and errors return zero data.
  always_comb begin
    w_rsp.err = w_err;
    if (w_err || tcb_wen) begin
      w_rsp.rdt = '0;
    end else if (PAR_MOD == TCB_MEMORY) begin
      w_rsp.rdt = w_rd_lanes;
    end else begin
      w_rsp.rdt = w_rdt_ref;
    end
  end

  // Memory write at the transfer edge; erroneous transfers leave memory untouched.
  always_ff @(posedge clk) begin
    if (w_xfr && tcb_wen && !w_err) begin
      for (int unsigned i = 0; i < BEW; i++) begin
        if (w_ben[i]) begin
          r_mem[{w_wrd, lane_sel(i)}] <= w_wdt[i*SLW +: SLW];
        end
      end
    end
  end

  // Ready rises on the first edge after reset release and never drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
    end
  end

  if (DLY == 0) begin : g_comb
    assign w_out_vld = w_xfr;
    assign w_out_rsp = w_rsp;
  end else begin : g_pipe
    logic [DLY-1:0] r_vld;
    tcb_rsp_t       r_rsp [DLY];

    // Response shift register: stage 0 captures at the transfer edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= '0;
        for (int unsigned k = 0; k < DLY; k++) begin
          r_rsp[k] <= '0;
        end
      end else begin
        r_vld[0] <= w_xfr;
        r_rsp[0] <= w_rsp;
        for (int unsigned k = 1; k < DLY; k++) begin
          r_vld[k] <= r_vld[k-1];
          r_rsp[k] <= r_rsp[k-1];
        end
      end
    end

    assign w_out_vld = r_vld[DLY-1];
    assign w_out_rsp = r_rsp[DLY-1];
  end

  // Remember the last delivered data so idle slots keep presenting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdt <= '0;
    end else if (w_out_vld) begin
      r_rdt <= w_out_rsp.rdt;
    end
  end

  assign tcb_rdt = w_out_vld ? w_out_rsp.rdt : r_rdt;
  assign tcb_err = w_out_vld & w_out_rsp.err;

endmodule
